stage_bundle_pipe: RTL and testbench

STAGE_BUNDLE_PIPE -- requirements
Module: stage_bundle_pipe

---
 rtl/stage_bundle_pipe.sv | 162 ++++++++++++++++
 tb/tb_stage_bundle_pipe.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_bundle_pipe.sv
// stage_bundle_pipe
// Two-entry (main + skid) buffered pipeline stage. It carries one bundle
// {y, t, x, n, ovf}, taken from either the "past" or the "new" input group.
// in_ready is decoded from registered state only, so there is no
// combinational path from out_ready back to in_ready.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   select                0 = take *_past bundle, 1 = take *_new bundle
//   y_*/t_*/x_*/n_*       candidate bundle fields
//   ovf_*/valid_*         candidate overflow flag and valid
//   flush                 synchronous discard of every buffered bundle
//   ovf_clr               synchronous clear of ovf_sticky
//   in_ready              the stage can accept a bundle this cycle
//   y, t, x, n, ovf       contents of the head (main) entry
//   v, out_ready          head valid / downstream consumes the head
//   last                  head is valid and is the final term (n == N_LAST)
//   ovf_sticky            some accepted bundle had ovf = 1
module stage_bundle_pipe #(
  parameter int              DATA_W = 32,
  parameter int              X_W    = 8,
  parameter int              N_W    = 4,
  parameter logic [N_W-1:0]  N_LAST = {N_W{1'b1}}  // 4'hF at the default width
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              select,
  input  logic [DATA_W-1:0] y_past,
  input  logic [DATA_W-1:0] y_new,
  input  logic [DATA_W-1:0] t_past,
  input  logic [DATA_W-1:0] t_new,
  input  logic [X_W-1:0]    x_past,
  input  logic [X_W-1:0]    x_new,
  input  logic [N_W-1:0]    n_past,
  input  logic [N_W-1:0]    n_new,
  input  logic              ovf_past,
  input  logic              ovf_new,
  input  logic              valid_past,
  input  logic              valid_new,
  input  logic              flush,
  input  logic              ovf_clr,
  output logic              in_ready,
  output logic [DATA_W-1:0] y,
  output logic [DATA_W-1:0] t,
  output logic [X_W-1:0]    x,
  output logic [N_W-1:0]    n,
  output logic              ovf,
  output logic              v,
  input  logic              out_ready,
  output logic              last,
  output logic              ovf_sticky
);

  typedef struct packed {
    logic [DATA_W-1:0] y;
    logic [DATA_W-1:0] t;
    logic [X_W-1:0]    x;
    logic [N_W-1:0]    n;
    logic              ovf;
  } bundle_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t  state_q, state_d;
  bundle_t main_q, skid_q;
  bundle_t sel_b;
  logic    sel_valid;
  logic    push, pop;
  logic    load_main, load_skid, main_from_skid;

  // Source mux: all fields switch together on select.
  always_comb begin
    if (select) begin
      sel_b     = '{y: y_new, t: t_new, x: x_new, n: n_new, ovf: ovf_new};
      sel_valid = valid_new;
    end else begin
      sel_b     = '{y: y_past, t: t_past, x: x_past, n: n_past, ovf: ovf_past};
      sel_valid = valid_past;
    end
  end

  assign in_ready = (state_q != FULL);
  assign v        = (state_q != EMPTY);
  assign push     = sel_valid & in_ready & ~flush;
  assign pop      = v & out_ready & ~flush;

  // NOTE: every output of this block gets a default first, so no path
  // through the case can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          state_d   = ONE;
          load_main = 1'b1;
        end
      end
      ONE: begin
        if (push && !pop) begin
          state_d   = FULL;
          load_skid = 1'b1;
        end else if (pop && !push) begin
          state_d = EMPTY;
        end else if (push && pop) begin
          load_main = 1'b1;  // head leaves, new bundle takes its place
        end
      end
      FULL: begin
        // in_ready is 0 here, so push cannot happen.
        if (pop) begin
          state_d        = ONE;
          load_main      = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    // push/pop are already gated by flush, so no entry is loaded either.
    if (flush) state_d = EMPTY;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // NOTE: the two data entries are reset as well, because the head fields
  // are visible on the outputs and must read zero while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main) main_q <= main_from_skid ? skid_q : sel_b;
      if (load_skid) skid_q <= sel_b;
    end
  end

  // A set from an accepted ovf bundle wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                ovf_sticky <= 1'b0;
    else if (push && sel_b.ovf) ovf_sticky <= 1'b1;
    else if (ovf_clr)          ovf_sticky <= 1'b0;
  end

  assign y    = main_q.y;
  assign t    = main_q.t;
  assign x    = main_q.x;
  assign n    = main_q.n;
  assign ovf  = main_q.ovf;
  assign last = v & (main_q.n == N_LAST);

endmodule

// File: tb/tb_stage_bundle_pipe.sv
// Self-checking bench for stage_bundle_pipe: a queue-based reference model
// of a two-deep FIFO plus directed scenarios with literal expectations.
module tb_stage_bundle_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        select;
  logic [31:0] y_past, y_new, t_past, t_new;
  logic [7:0]  x_past, x_new;
  logic [3:0]  n_past, n_new;
  logic        ovf_past, ovf_new, valid_past, valid_new;
  logic        flush, ovf_clr, out_ready;
  logic        in_ready, v, last, ovf_sticky, ovf;
  logic [31:0] y, t;
  logic [7:0]  x;
  logic [3:0]  n;

  int n_checks = 0;
  int n_fail   = 0;

  stage_bundle_pipe dut (
    .clk(clk), .rst_n(rst_n), .select(select),
    .y_past(y_past), .y_new(y_new), .t_past(t_past), .t_new(t_new),
    .x_past(x_past), .x_new(x_new), .n_past(n_past), .n_new(n_new),
    .ovf_past(ovf_past), .ovf_new(ovf_new),
    .valid_past(valid_past), .valid_new(valid_new),
    .flush(flush), .ovf_clr(ovf_clr), .in_ready(in_ready),
    .y(y), .t(t), .x(x), .n(n), .ovf(ovf), .v(v),
    .out_ready(out_ready), .last(last), .ovf_sticky(ovf_sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] y;
    logic [31:0] t;
    logic [7:0]  x;
    logic [3:0]  n;
    logic        ovf;
  } bundle_t;

  bundle_t q[$];
  logic    sticky_m = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      sticky_m = 1'b0;
    end else begin
      bundle_t b;
      logic    bv, do_push, do_pop;
      b  = select ? '{y_new, t_new, x_new, n_new, ovf_new}
                  : '{y_past, t_past, x_past, n_past, ovf_past};
      bv = select ? valid_new : valid_past;
      do_push = bv && (q.size() < 2) && !flush;
      do_pop  = (q.size() > 0) && out_ready && !flush;
      if (flush) q.delete();
      else begin
        if (do_pop)  void'(q.pop_front());
        if (do_push) q.push_back(b);
      end
      if (do_push && b.ovf) sticky_m = 1'b1;
      else if (ovf_clr)     sticky_m = 1'b0;
    end
  end

  // Compare process: every falling edge, away from the active edge.
  always @(negedge clk) begin
    check("in_ready", in_ready, q.size() < 2);
    check("v", v, q.size() != 0);
    check("ovf_sticky", ovf_sticky, sticky_m);
    if (q.size() != 0) begin
      check("y", y, q[0].y);
      check("t", t, q[0].t);
      check("x", x, q[0].x);
      check("n", n, q[0].n);
      check("ovf", ovf, q[0].ovf);
      check("last", last, q[0].n == 4'hF);
    end else begin
      check("last_empty", last, 1'b0);
    end
    if (!rst_n) check("reset_fields", {y, t, x, n, ovf}, 64'h0) ;
  end

  // ---------------- stimulus ----------------
  task automatic idle_inputs();
    select = 1'b0; valid_past = 1'b0; valid_new = 1'b0;
    y_past = '0; y_new = '0; t_past = '0; t_new = '0;
    x_past = '0; x_new = '0; n_past = '0; n_new = '0;
    ovf_past = 1'b0; ovf_new = 1'b0; flush = 1'b0; ovf_clr = 1'b0;
  endtask

  // Advance one edge; inputs set before the call are sampled there.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_new(input logic [31:0] val, input logic o);
    select = 1'b1; valid_new = 1'b1; y_new = val; t_new = ~val;
    x_new = val[7:0]; n_new = val[3:0]; ovf_new = o;
  endtask

  initial begin
    idle_inputs();
    out_ready = 1'b0;
    rst_n     = 1'b0;
    #3;
    check("rst_v", v, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_y", y, 32'h0);
    check("rst_sticky", ovf_sticky, 1'b0);
    cycle(); cycle();
    #3 rst_n = 1'b1;
    cycle();

    // Single pass
    out_ready = 1'b1;
    select = 1'b1; y_new = 32'h0000_1234; n_new = 4'd3; valid_new = 1'b1;
    cycle();
    valid_new = 1'b0;
    check("sp_v", v, 1'b1);
    check("sp_y", y, 32'h0000_1234);
    check("sp_n", n, 4'd3);
    check("sp_last", last, 1'b0);
    cycle();
    check("sp_v_after", v, 1'b0);

    // Backpressure and order
    out_ready = 1'b0;
    push_new(32'd1, 1'b0); cycle();
    push_new(32'd2, 1'b0); cycle();
    valid_new = 1'b0;
    check("bp_in_ready_full", in_ready, 1'b0);
    check("bp_head_a", y, 32'd1);
    out_ready = 1'b1; cycle();
    check("bp_head_b", y, 32'd2);
    check("bp_in_ready_back", in_ready, 1'b1);
    cycle();
    check("bp_drained", v, 1'b0);

    // Select and last
    idle_inputs();
    out_ready = 1'b0;
    select = 1'b0; valid_past = 1'b1; n_past = 4'hF; ovf_past = 1'b1; y_past = 32'd5;
    y_new = '1; t_new = '1; x_new = '1; n_new = '1; ovf_new = 1'b1; valid_new = 1'b1;
    cycle();
    idle_inputs();
    check("sl_n", n, 4'hF);
    check("sl_y", y, 32'd5);
    check("sl_last", last, 1'b1);
    check("sl_ovf", ovf, 1'b1);
    check("sl_sticky", ovf_sticky, 1'b1);
    ovf_clr = 1'b1; cycle(); ovf_clr = 1'b0;
    check("sl_sticky_clr", ovf_sticky, 1'b0);
    check("sl_held_v", v, 1'b1);
    // set and clear together: set wins
    out_ready = 1'b1; push_new(32'd6, 1'b1); ovf_clr = 1'b1; cycle();
    idle_inputs();
    check("sl_set_wins", ovf_sticky, 1'b1);
    check("sl_head6", y, 32'd6);
    ovf_clr = 1'b1; cycle(); ovf_clr = 1'b0;

    // Concurrency
    out_ready = 1'b0; push_new(32'd10, 1'b0); cycle();
    out_ready = 1'b1; push_new(32'd11, 1'b0); cycle();
    check("cc_head_c", y, 32'd11);
    check("cc_one_ready", in_ready, 1'b1);
    out_ready = 1'b0; push_new(32'd12, 1'b0); cycle();
    valid_new = 1'b0;
    check("cc_full", in_ready, 1'b0);
    out_ready = 1'b1; cycle();
    check("cc_skid_to_main", y, 32'd12);
    check("cc_one_again", in_ready, 1'b1);
    cycle();

    // Flush
    out_ready = 1'b0; push_new(32'd20, 1'b1); cycle();
    push_new(32'd21, 1'b0); cycle();
    out_ready = 1'b1; push_new(32'd22, 1'b0); flush = 1'b1; cycle();
    idle_inputs();
    check("fl_v", v, 1'b0);
    check("fl_ready", in_ready, 1'b1);
    check("fl_sticky_kept", ovf_sticky, 1'b1);
    cycle();
    check("fl_still_empty", v, 1'b0);

    // Async reset mid-operation
    out_ready = 1'b0; push_new(32'd30, 1'b1); cycle();
    push_new(32'd31, 1'b0); cycle();
    valid_new = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("ar_v", v, 1'b0);
    check("ar_ready", in_ready, 1'b1);
    check("ar_sticky", ovf_sticky, 1'b0);
    check("ar_y", y, 32'h0);
    cycle();
    #2 rst_n = 1'b1;
    cycle();
    out_ready = 1'b1; push_new(32'd40, 1'b0); cycle();
    valid_new = 1'b0;
    check("ar_push_y", y, 32'd40);
    check("ar_push_v", v, 1'b1);
    cycle();
    check("ar_only_one", v, 1'b0);

    // Mixed traffic, checked by the model only
    for (int i = 0; i < 24; i++) begin
      select     = i[0];
      valid_new  = (i % 3) != 0;
      valid_past = (i % 4) != 1;
      y_new = 32'd100 + i;  y_past = 32'd200 + i;
      t_new = ~y_new;       t_past = ~y_past;
      x_new = 8'(i * 3);    x_past = 8'(i * 5);
      n_new = 4'(i);        n_past = 4'(i + 1);
      ovf_new = (i == 7);   ovf_past = 1'b0;
      out_ready = (i % 5) < 3;
      flush   = (i == 17);
      ovf_clr = (i == 20);
      cycle();
    end
    idle_inputs();
    out_ready = 1'b1;
    cycle(); cycle(); cycle();
    check("mix_drained", v, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
